regfile_fwd: RTL and testbench
==============================

REGFILE_FWD -- requirements
Module: regfile_fwd

Interface
REQ-001 SHALL have parameter DATA, default 32: width of each register in bits.
REQ-002 SHALL have parameter ADDR, default 5: address width; depth is 2**ADDR.
REQ-003 SHALL have parameter READ, default 4: number of read ports.
REQ-004 SHALL have parameter WRITE, default 4: number of write ports.
REQ-005 SHALL have parameter ZERO_REG, default Enable: register 0 is hardwired to zero.
REQ-006 SHALL have parameter BYPASS, default Enable: same-cycle write-to-read forwarding.
REQ-007 SHALL have parameter RD_LAT, default 0: read latency in cycles; legal values are 0 and 1.
REQ-008 SHALL have port clk, input, width 1: the single clock; all state updates on the rising edge.
REQ-009 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-010 SHALL have port raddr, input, width ADDR*READ: read addresses; port i uses slice [i*ADDR +: ADDR].
REQ-011 SHALL have port rdata, output, width DATA*READ: read data, per-port slices.
REQ-012 SHALL have port rbusy, output, width READ: busy status of the register addressed by each read port.
REQ-013 SHALL have port waddr, input, width ADDR*WRITE: write addresses.
REQ-014 SHALL have port we_, input, width WRITE: active-low write enables.
REQ-015 SHALL have port wdata, input, width DATA*WRITE: write data.
REQ-016 SHALL have port alloc_, input, width WRITE: active-low busy-set strobes.
REQ-017 SHALL have port alloc_addr, input, width ADDR*WRITE: registers to mark busy.
REQ-018 SHALL have port flush, input, width 1: active-high; clears all busy bits.

Function
REQ-019 SHALL write regs[waddr_i] <= wdata_i at the rising edge for every port with we_[i]=0.
REQ-020 When several enabled write ports target one address, the highest-indexed port SHALL win.
REQ-021 With ZERO_REG, address 0 SHALL ignore writes, read as 0, and never be busy.
REQ-022 With RD_LAT=0, rdata SHALL be combinational from raddr.
REQ-023 With RD_LAT=0 and BYPASS, a read matching an enabled same-cycle write address SHALL return that wdata (highest port wins); otherwise it SHALL return the stored value.
REQ-024 With RD_LAT=1, raddr SHALL be sampled at the edge and rdata presented one cycle later.
REQ-025 With RD_LAT=1, the presented value SHALL include any write committed at that same edge, regardless of BYPASS.
REQ-026 A busy bit SHALL be set by alloc_[i]=0 and cleared by an enabled write to that address.
REQ-027 When alloc and write target the same address in one cycle, alloc SHALL win and the bit ends set.
REQ-028 Flush SHALL clear all busy bits, override alloc in the same cycle, and SHALL NOT block writes.
REQ-029 rbusy[i] SHALL be the busy bit of raddr_i; with BYPASS and RD_LAT=0 it SHALL read 0 when a same-cycle write matches.
REQ-030 With RD_LAT=1, rbusy SHALL be registered alongside rdata with identical timing.

Reset
REQ-031 Asserting reset SHALL immediately clear all registers, all busy bits, and the RD_LAT=1 output registers to 0.
REQ-032 Reset asserted mid-operation SHALL discard writes and allocs in that cycle, and rdata/rbusy SHALL read 0 until reset is released.

Structure
REQ-033 The RD_LAT legal-value constants and the per-port slice-width helper SHALL live in a shared package, regfile_pkg.
REQ-034 Forwarding and write-priority selection SHALL be one sub-module, regfile_fwd_sel, instanced per read port.

Verification
REQ-035 Bench SHALL cover: ports 0-3 write 31/1/2/3 to addresses 31/1/2/3; next cycle reads return 31, 1, 2, 3.
REQ-036 Bench SHALL cover: port 0 writes 0xdeadbeef to address 0 with ZERO_REG -> address 0 reads 0 and rbusy=0.
REQ-037 Bench SHALL cover: ports 1 and 3 write 0x10 and 0x30 to address 4 in the same cycle -> address 4 holds 0x30.
REQ-038 Bench SHALL cover: BYPASS, RD_LAT=0, write 0x20 to address 5 while reading address 5 -> rdata=0x20 in the same cycle and rbusy=0.
REQ-039 Bench SHALL cover: alloc address 6, then one cycle later write 0x30 to address 6 plus alloc address 6 -> rbusy stays 1; flush -> 0.
REQ-040 Bench SHALL cover: RD_LAT=1 with reset asserted mid-read -> rdata=0 immediately, and register 31 reads 0 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and slice helper for the forwarding register file
package regfile_pkg;

  // Read-latency modes: combinational read or one registered stage.
  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

  // Low bit of the slice belonging to port 'port' in a packed per-port bus.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_fwd_sel.sv
// rtl/regfile_fwd_sel.sv - per-read-port write priority and forwarding select
module regfile_fwd_sel
  import regfile_pkg::*;
#(
  parameter int DATA     = 32,
  parameter int ADDR     = 5,
  parameter int WRITE    = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit FWD_DATA = 1'b1,
  parameter bit FWD_BUSY = 1'b1
) (
  input  logic [ADDR-1:0]       i_raddr,
  input  logic [ADDR*WRITE-1:0] i_waddr,
  input  logic [WRITE-1:0]      i_we_n,
  input  logic [DATA*WRITE-1:0] i_wdata,
  input  logic [DATA-1:0]       i_stored,
  input  logic                  i_busy,
  output logic [DATA-1:0]       o_data,
  output logic                  o_busy
);

  logic            w_hit;
  logic [DATA-1:0] w_hit_data;
  logic            w_zero;

  // Scan write ports low to high so the highest-indexed matching port wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int i = 0; i < WRITE; i++) begin
      if (!i_we_n[i] && (i_waddr[slice_lo(i, ADDR) +: ADDR] == i_raddr)) begin
        w_hit      = 1'b1;
        w_hit_data = i_wdata[slice_lo(i, DATA) +: DATA];
      end
    end
  end

  assign w_zero = ZERO_REG && (i_raddr == '0);

  // Register 0 dominates; otherwise a matching write replaces the stored value
  // and, when forwarding busy, reports the register as no longer busy.
  always_comb begin
    o_data = i_stored;
    o_busy = i_busy;
    if (w_zero) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (w_hit) begin
      if (FWD_DATA) begin
        o_data = w_hit_data;
      end
      if (FWD_BUSY) begin
        o_busy = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_fwd.sv
// rtl/regfile_fwd.sv - multi-port register file with busy scoreboard and write forwarding
module regfile_fwd
  import regfile_pkg::*;
#(
  parameter int DATA     = 32,
  parameter int ADDR     = 5,
  parameter int READ     = 4,
  parameter int WRITE    = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int RD_LAT   = RD_LAT_COMB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR*READ-1:0]  raddr,
  output logic [DATA*READ-1:0]  rdata,
  output logic [READ-1:0]       rbusy,
  input  logic [ADDR*WRITE-1:0] waddr,
  input  logic [WRITE-1:0]      we_,
  input  logic [DATA*WRITE-1:0] wdata,
  input  logic [WRITE-1:0]      alloc_,
  input  logic [ADDR*WRITE-1:0] alloc_addr,
  input  logic                  flush
);

  localparam int  DEPTH   = 1 << ADDR;
  localparam bit  REG_OUT = (RD_LAT == RD_LAT_REG);
  // A registered read always reflects the write committed at its sampling
  // edge; a combinational read forwards only when bypass is enabled.
  localparam bit  FWD_D   = REG_OUT ? 1'b1 : BYPASS;
  localparam bit  FWD_B   = !REG_OUT && BYPASS;

  logic [DATA-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [WRITE-1:0] w_we_n;

  // While reset is held no write may reach the array or be forwarded.
  assign w_we_n = we_ | {WRITE{reset}};

  // Commit enabled writes; later ports overwrite earlier ones so the highest index wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int i = 0; i < WRITE; i++) begin
        if (!we_[i] && !(ZERO_REG && (waddr[slice_lo(i, ADDR) +: ADDR] == '0))) begin
          r_regs[waddr[slice_lo(i, ADDR) +: ADDR]] <= wdata[slice_lo(i, DATA) +: DATA];
        end
      end
    end
  end

  // Next busy state: writes clear, allocs set afterwards so they win, flush clears everything.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < WRITE; i++) begin
      if (!we_[i]) begin
        w_busy_nxt[waddr[slice_lo(i, ADDR) +: ADDR]] = 1'b0;
      end
    end
    for (int i = 0; i < WRITE; i++) begin
      if (!alloc_[i]) begin
        w_busy_nxt[alloc_addr[slice_lo(i, ADDR) +: ADDR]] = 1'b1;
      end
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
    if (ZERO_REG) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar g = 0; g < READ; g++) begin : g_rd
    logic [ADDR-1:0] w_ra;
    logic [DATA-1:0] w_data;
    logic            w_bsy_src;
    logic            w_bsy;

    assign w_ra      = raddr[g*ADDR +: ADDR];
    // A registered read presents the busy state that takes effect at its edge.
    assign w_bsy_src = REG_OUT ? w_busy_nxt[w_ra] : r_busy[w_ra];

    regfile_fwd_sel #(
      .DATA     (DATA),
      .ADDR     (ADDR),
      .WRITE    (WRITE),
      .ZERO_REG (ZERO_REG),
      .FWD_DATA (FWD_D),
      .FWD_BUSY (FWD_B)
    ) u_sel (
      .i_raddr  (w_ra),
      .i_waddr  (waddr),
      .i_we_n   (w_we_n),
      .i_wdata  (wdata),
      .i_stored (r_regs[w_ra]),
      .i_busy   (w_bsy_src),
      .o_data   (w_data),
      .o_busy   (w_bsy)
    );

    if (REG_OUT) begin : g_reg
      logic [DATA-1:0] r_data;
      logic            r_bsy;

      // Output stage: data and busy share one register slot so their timing matches.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_data <= '0;
          r_bsy  <= 1'b0;
        end else begin
          r_data <= w_data;
          r_bsy  <= w_bsy;
        end
      end

      assign rdata[g*DATA +: DATA] = r_data;
      assign rbusy[g]              = r_bsy;
    end else begin : g_comb
      assign rdata[g*DATA +: DATA] = w_data;
      assign rbusy[g]              = w_bsy;
    end
  end

endmodule

// File: tb/tb_regfile_fwd.sv
// tb/tb_regfile_fwd.sv - scoreboard bench for regfile_fwd in combinational and registered read modes
module tb_regfile_fwd;

  logic         clk;
  logic         reset;
  logic [19:0]  raddr;
  logic [19:0]  waddr;
  logic [19:0]  alloc_addr;
  logic [127:0] wdata;
  logic [3:0]   we_;
  logic [3:0]   alloc_;
  logic         flush;
  logic [127:0] rdata0, rdata1;
  logic [3:0]   rbusy0, rbusy1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          dut;
    bit          is_busy;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;

  regfile_fwd u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .raddr      (raddr),
    .rdata      (rdata0),
    .rbusy      (rbusy0),
    .waddr      (waddr),
    .we_        (we_),
    .wdata      (wdata),
    .alloc_     (alloc_),
    .alloc_addr (alloc_addr),
    .flush      (flush)
  );

  regfile_fwd #(.RD_LAT(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .raddr      (raddr),
    .rdata      (rdata1),
    .rbusy      (rbusy1),
    .waddr      (waddr),
    .we_        (we_),
    .wdata      (wdata),
    .alloc_     (alloc_),
    .alloc_addr (alloc_addr),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input int dut, input bit is_busy, input int port);
    logic [127:0] d;
    logic [3:0]   b;
    d = (dut == 0) ? rdata0 : rdata1;
    b = (dut == 0) ? rbusy0 : rbusy1;
    if (is_busy) return {31'd0, b[port]};
    return d[port*32 +: 32];
  endfunction

  task automatic exp_d(input string name, input int dut, input int port, input logic [31:0] v);
    exp_t e;
    e.name = name; e.dut = dut; e.is_busy = 1'b0; e.port = port; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic exp_b(input string name, input int dut, input int port, input logic v);
    exp_t e;
    e.name = name; e.dut = dut; e.is_busy = 1'b1; e.port = port; e.exp = {31'd0, v};
    sb_q.push_back(e);
  endtask

  // Monitor: drains the scoreboard at each sample point.
  initial begin
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge clk or sample_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = actual(e.dut, e.is_busy, e.port);
        checks++;
        if (a !== e.exp) begin
          failures++;
          $display("FAIL %s: dut%0d port%0d %s got 0x%08h expected 0x%08h",
                   e.name, e.dut, e.port, e.is_busy ? "rbusy" : "rdata", a, e.exp);
        end
      end
    end
  end

  task automatic clr();
    we_ = 4'hF; alloc_ = 4'hF; flush = 1'b0;
    waddr = '0; wdata = '0; alloc_addr = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we_[p] = 1'b0; waddr[p*5 +: 5] = a; wdata[p*32 +: 32] = d;
  endtask

  task automatic al(input int p, input logic [4:0] a);
    alloc_[p] = 1'b0; alloc_addr[p*5 +: 5] = a;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    raddr[p*5 +: 5] = a;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clr();
    raddr = '0;
    rd(0, 5'd31); rd(1, 5'd1); rd(2, 5'd2); rd(3, 5'd3);
    #2;
    for (int p = 0; p < 4; p++) exp_d("reset_rdata", 0, p, 32'd0);
    for (int p = 0; p < 4; p++) exp_b("reset_rbusy", 0, p, 1'b0);
    exp_d("reset_rdata_lat1", 1, 0, 32'd0);
    exp_b("reset_rbusy_lat1", 1, 0, 1'b0);
    cyc();

    // c1: four ports write 31/1/2/3 while reading them back through the bypass
    cyc(); reset = 1'b0;
    wr(0, 5'd31, 32'd31); wr(1, 5'd1, 32'd1); wr(2, 5'd2, 32'd2); wr(3, 5'd3, 32'd3);
    exp_d("bypass_multi", 0, 0, 32'd31); exp_d("bypass_multi", 0, 1, 32'd1);
    exp_d("bypass_multi", 0, 2, 32'd2);  exp_d("bypass_multi", 0, 3, 32'd3);

    // c2: stored values; registered read shows writes committed at its edge
    cyc();
    exp_d("stored_multi", 0, 0, 32'd31); exp_d("stored_multi", 0, 1, 32'd1);
    exp_d("stored_multi", 0, 2, 32'd2);  exp_d("stored_multi", 0, 3, 32'd3);
    exp_d("lat1_commit", 1, 0, 32'd31);  exp_d("lat1_commit", 1, 1, 32'd1);
    exp_d("lat1_commit", 1, 2, 32'd2);   exp_d("lat1_commit", 1, 3, 32'd3);

    // c3: write and alloc to register 0
    cyc();
    wr(0, 5'd0, 32'hdeadbeef); al(0, 5'd0); rd(0, 5'd0);
    exp_d("zero_bypass", 0, 0, 32'd0); exp_b("zero_bypass_busy", 0, 0, 1'b0);

    // c4
    cyc();
    exp_d("zero_stored", 0, 0, 32'd0); exp_b("zero_busy", 0, 0, 1'b0);
    exp_d("zero_lat1", 1, 0, 32'd0);   exp_b("zero_busy_lat1", 1, 0, 1'b0);

    // c5: ports 1 and 3 collide on address 4
    cyc();
    wr(1, 5'd4, 32'h10); wr(3, 5'd4, 32'h30); rd(1, 5'd4);
    exp_d("prio_bypass", 0, 1, 32'h30);

    // c6: stored winner; allocate address 5
    cyc();
    al(2, 5'd5); rd(2, 5'd5);
    exp_d("prio_stored", 0, 1, 32'h30); exp_d("prio_lat1", 1, 1, 32'h30);
    exp_b("alloc_not_yet", 0, 2, 1'b0);

    // c7: write 0x20 to busy address 5 while reading it
    cyc();
    wr(2, 5'd5, 32'h20);
    exp_d("same_cycle_fwd", 0, 2, 32'h20); exp_b("same_cycle_busy", 0, 2, 1'b0);
    exp_b("lat1_alloc_busy", 1, 2, 1'b1);  exp_d("lat1_old_data", 1, 2, 32'd0);

    // c8
    cyc();
    exp_d("fwd_stored", 0, 2, 32'h20); exp_b("write_clears", 0, 2, 1'b0);
    exp_d("fwd_lat1", 1, 2, 32'h20);   exp_b("write_clears_lat1", 1, 2, 1'b0);

    // c9: allocate address 6
    cyc();
    al(0, 5'd6); rd(0, 5'd6);
    exp_b("alloc6_pre", 0, 0, 1'b0);

    // c10: write plus alloc to address 6
    cyc();
    wr(1, 5'd6, 32'h30); al(0, 5'd6);
    exp_d("alloc_wr_fwd", 0, 0, 32'h30); exp_b("alloc_wr_bypass", 0, 0, 1'b0);
    exp_b("alloc6_lat1", 1, 0, 1'b1);

    // c11: alloc won; flush now
    cyc();
    flush = 1'b1;
    exp_b("alloc_wins", 0, 0, 1'b1); exp_d("alloc_wr_data", 0, 0, 32'h30);
    exp_b("alloc_wins_lat1", 1, 0, 1'b1);

    // c12: flush again with a competing alloc and a write
    cyc();
    flush = 1'b1; al(0, 5'd7); wr(1, 5'd8, 32'h77);
    exp_b("flush_clears", 0, 0, 1'b0); exp_b("flush_clears_lat1", 1, 0, 1'b0);

    // c13
    cyc();
    rd(0, 5'd7); rd(1, 5'd8);
    exp_b("flush_over_alloc", 0, 0, 1'b0); exp_d("flush_keeps_write", 0, 1, 32'h77);

    // c14, c15: registered read of 31, then reset in mid-read
    cyc();
    rd(0, 5'd31);
    cyc();
    exp_d("lat1_pre_reset", 1, 0, 32'd31);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_d("reset_async_lat1", 1, 0, 32'd0); exp_b("reset_async_busy1", 1, 0, 1'b0);
    exp_d("reset_async_lat0", 0, 0, 32'd0);
    ->sample_ev;

    // c16: reset held; write and alloc are discarded
    cyc();
    wr(0, 5'd31, 32'h55); al(1, 5'd9); rd(1, 5'd9);
    exp_d("reset_held_lat0", 0, 0, 32'd0); exp_d("reset_held_lat1", 1, 0, 32'd0);
    exp_b("reset_held_busy", 0, 1, 1'b0);

    // c17: release
    cyc();
    reset = 1'b0;
    exp_d("post_reset_r31", 0, 0, 32'd0); exp_b("post_reset_busy9", 0, 1, 1'b0);
    exp_d("post_reset_lat1_out", 1, 0, 32'd0);

    // c18
    cyc();
    exp_d("post_reset_r31_lat1", 1, 0, 32'd0); exp_b("post_reset_busy9_lat1", 1, 1, 1'b0);
    exp_d("post_reset_r31_again", 0, 0, 32'd0);

    cyc();
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
